mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the RV32I 5-stage pipeline: consumes EX/MEM register outputs and drives the MEM/WB register.
- Performs loads/stores over a req/ack data-memory port with byte-lane steering, load sign/zero extension, misalignment checks and an ack timeout.
- Stalls upstream while an access is outstanding.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
TIMEOUT_CYCLES, 255, max cycles dmem_req may stay high without dmem_ack before the access is aborted (range 1..2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
valid_in  in  1  EX/MEM holds a valid instruction
alu_result_in  in  32  byte address for memory ops; result for others
rs2_val_in  in  32  store data
rd_in  in  5  destination register
funct3_in  in  3  load/store width/sign code
reg_write_in  in  1  instruction writes rd
mem_read_in  in  1  load
mem_write_in  in  1  store
mem_to_reg_in  in  1  writeback selects load data
stall_out  out  1  combinational; upstream holds EX/MEM contents while high
dmem_req  out  1  registered access request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-aligned store data
dmem_rdata  in  32  read word, valid with dmem_ack
dmem_ack  in  1  single-cycle completion pulse
valid_out  out  1  MEM/WB entry valid
wb_data_out  out  32  writeback value
rd_out  out  5  destination register
reg_write_out  out  1  write enable to WB
fault_out  out  1  1-cycle pulse with faulting instruction's valid_out
fault_cause_out  out  2  01 misaligned, 10 timeout, 11 illegal funct3

Behaviour:
- Clock/reset: one clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Memory op: valid_in & (mem_read_in | mem_write_in).
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes raise fault 11.
- Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
- FSM IDLE:
  - Non-memory valid instruction: next edge valid_out=1, wb_data_out=alu_result_in, rd/reg_write copied, fault_out=0.
  - valid_in=0: next edge valid_out=0, reg_write_out=0; wb_data_out/rd_out hold.
  - Faulting memory op: no request; next edge valid_out=1, reg_write_out=0, fault_out=1 with cause.
  - Legal aligned memory op (start): stall_out=1; at edge latch rd, funct3, addr[1:0], mem_to_reg, reg_write; set dmem_req=1 plus we/addr/be/wdata; go WAIT; valid_out=0.
- Byte enables and store data:
  - SB: be = 0001<<addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011<<addr[1:0]; wdata = half replicated x2.
  - SW: be = 1111.
  - Loads: be=1111, we=0.
- FSM WAIT:
  - stall_out = !dmem_ack.
  - Request fields held stable until ack.
  - On ack: dmem_req=0 and return to IDLE at that edge.
  - Load completion: valid_out=1, wb_data_out = extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); reg_write_out as latched.
  - Store completion: valid_out=1, reg_write_out=0.
  - Counter increments each WAIT cycle without ack.
  - Timeout: counter reaches TIMEOUT_CYCLES-1 with no ack, so abort after TIMEOUT_CYCLES cycles of req. Drop req, go IDLE, valid_out=1, reg_write_out=0, fault_out=1, cause 10.
  - Ack on the final timeout cycle: ack wins, normal completion.
- Minimum memory-op latency: acceptance edge + ack in first WAIT cycle gives result 2 edges after acceptance.
- Ignored inputs: dmem_ack in IDLE; dmem_rdata outside ack cycle.
- Reset during WAIT: next edge dmem_req=0, IDLE, counter cleared, no valid_out; a late ack is ignored.
- Counter is cleared on entry to WAIT.
- mem_to_reg_in=0 on a load: wb_data_out=alu_result_in.

Test Plan:
- Non-mem: valid_in=1, alu_result_in=0x1234, rd_in=5, reg_write_in=1 -> next edge valid_out=1, wb_data_out=0x1234, rd_out=5, stall_out=0.
- LB addr 0x103, ack after 3 wait cycles with rdata=0x80FF_FF7F -> dmem_addr=0x100, be=1111, stall_out high 4 cycles, wb_data_out=0xFFFF_FF80, reg_write_out=1.
- SH addr 0x2002, rs2=0xDEAD_BEEF -> be=1100, wdata=0xBEEF_BEEF, we=1; on ack valid_out=1, reg_write_out=0.
- LW addr 0x5 -> no dmem_req, valid_out=1, reg_write_out=0, fault_out=1, cause=01. funct3=011 load -> cause=11.
- TIMEOUT_CYCLES=4, LW with no ack -> req high exactly 4 cycles, then fault cause=10, stall_out low. Repeat with ack in 4th cycle -> normal completion, no fault.
- Reset asserted in 2nd WAIT cycle -> next edge dmem_req=0, valid_out=0. Following ack ignored; next non-mem instruction completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the RV32I 5-stage pipeline: issues loads/stores on a req/ack data port,
// steers byte lanes, extends load data and aborts accesses that are never acknowledged.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_val_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        fault_out,
  output logic [1:0]  fault_cause_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          r_state, w_next_state;
  logic [TO_W-1:0] r_to_cnt;
  logic [2:0]      r_funct3;
  logic [1:0]      r_lane;
  logic            r_mem_to_reg, r_reg_write;
  logic [4:0]      r_rd;
  logic [31:0]     r_alu;

  logic        w_mem_op, w_legal, w_misaligned, w_start, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_mem_op = valid_in & (mem_read_in | mem_write_in);

  // Loads take priority if both read and write are flagged.
  always_comb begin
    if (mem_read_in)
      w_legal = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      w_legal = funct3_in inside {3'b000, 3'b001, 3'b010};
  end

  assign w_misaligned = ((funct3_in[1:0] == 2'b01) &  alu_result_in[0]) |
                        ((funct3_in[1:0] == 2'b10) & (alu_result_in[1:0] != 2'b00));
  assign w_start      = (r_state == IDLE) & w_mem_op & w_legal & ~w_misaligned;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_val_in;
    if (!mem_read_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          w_be    = 4'b0001 << alu_result_in[1:0];
          w_wdata = {4{rs2_val_in[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << alu_result_in[1:0];
          w_wdata = {2{rs2_val_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_byte = dmem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = dmem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // NOTE: every output of this block is assigned a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    stall_out    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: if (w_start) begin
        stall_out    = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        stall_out = ~dmem_ack;
        w_timeout = ~dmem_ack & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        if (dmem_ack | w_timeout) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_to_cnt        <= '0;
      r_funct3        <= '0;
      r_lane          <= '0;
      r_mem_to_reg    <= 1'b0;
      r_reg_write     <= 1'b0;
      r_rd            <= '0;
      r_alu           <= '0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_be         <= '0;
      dmem_wdata      <= '0;
      valid_out       <= 1'b0;
      wb_data_out     <= '0;
      rd_out          <= '0;
      reg_write_out   <= 1'b0;
      fault_out       <= 1'b0;
      fault_cause_out <= '0;
    end else begin
      r_state         <= w_next_state;
      valid_out       <= 1'b0;
      reg_write_out   <= 1'b0;
      fault_out       <= 1'b0;
      fault_cause_out <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_funct3     <= funct3_in;
            r_lane       <= alu_result_in[1:0];
            r_mem_to_reg <= mem_to_reg_in;
            r_reg_write  <= reg_write_in;
            r_rd         <= rd_in;
            r_alu        <= alu_result_in;
            r_to_cnt     <= '0;
            dmem_req     <= 1'b1;
            dmem_we      <= ~mem_read_in;
            dmem_addr    <= {alu_result_in[31:2], 2'b00};
            dmem_be      <= w_be;
            dmem_wdata   <= w_wdata;
          end else if (valid_in) begin
            valid_out   <= 1'b1;
            wb_data_out <= alu_result_in;
            rd_out      <= rd_in;
            if (w_mem_op) begin
              fault_out       <= 1'b1;
              fault_cause_out <= w_legal ? 2'b01 : 2'b11;
            end else begin
              reg_write_out <= reg_write_in;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            valid_out     <= 1'b1;
            rd_out        <= r_rd;
            reg_write_out <= r_reg_write & ~dmem_we;
            wb_data_out   <= (~dmem_we & r_mem_to_reg) ? w_load_data : r_alu;
          end else if (w_timeout) begin
            dmem_req        <= 1'b0;
            valid_out       <= 1'b1;
            rd_out          <= r_rd;
            fault_out       <= 1'b1;
            fault_cause_out <= 2'b10;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a 4-cycle ack timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result_in, rs2_val_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        valid_out;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out, fault_out;
  logic [1:0]  fault_cause_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .rs2_val_in(rs2_val_in), .rd_in(rd_in), .funct3_in(funct3_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .valid_out(valid_out),
    .wb_data_out(wb_data_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .fault_out(fault_out), .fault_cause_out(fault_cause_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                       input logic mr, input logic mw, input logic m2r);
    valid_in = v; alu_result_in = alu; rs2_val_in = rs2; rd_in = rd; funct3_in = f3;
    reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; mem_to_reg_in = m2r;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load acknowledged in the first WAIT cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic m2r, input logic [31:0] exp);
    drive(1'b1, addr, 32'h0, 5'd9, f3, 1'b1, 1'b1, 1'b0, m2r);
    tick();
    idle_in();
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_0000;
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_wb"}, wb_data_out, exp);
  endtask

  int stall_cnt;
  int req_cnt;

  initial begin
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    idle_in();
    tick(); tick();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_wb", wb_data_out, 32'h0);
    check("rst_fault", 32'(fault_out), 32'd0);
    reset = 1'b0;

    // Non-memory pass-through, then a bubble that holds wb/rd.
    drive(1'b1, 32'h1234, 32'h0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("nm_stall", 32'(stall_out), 32'd0);
    tick();
    check("nm_valid", 32'(valid_out), 32'd1);
    check("nm_wb", wb_data_out, 32'h1234);
    check("nm_rd", 32'(rd_out), 32'd5);
    check("nm_rw", 32'(reg_write_out), 32'd1);
    idle_in();
    tick();
    check("bub_valid", 32'(valid_out), 32'd0);
    check("bub_rw", 32'(reg_write_out), 32'd0);
    check("bub_wb_hold", wb_data_out, 32'h1234);

    // LB at 0x103, ack in the fourth WAIT cycle (also the final timeout cycle).
    stall_cnt = 0;
    drive(1'b1, 32'h103, 32'h0, 5'd7, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 if (stall_out) stall_cnt++;
    tick();
    idle_in();
    check("lb_req", 32'(dmem_req), 32'd1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_be", 32'(dmem_be), 32'hF);
    check("lb_we", 32'(dmem_we), 32'd0);
    check("lb_valid_wait", 32'(valid_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (stall_out) stall_cnt++;
      tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F;
    #1 if (stall_out) stall_cnt++;
    tick();
    dmem_ack = 1'b0;
    check("lb_stall_cycles", 32'(stall_cnt), 32'd4);
    check("lb_valid", 32'(valid_out), 32'd1);
    check("lb_wb", wb_data_out, 32'hFFFF_FF80);
    check("lb_rw", 32'(reg_write_out), 32'd1);
    check("lb_rd", 32'(rd_out), 32'd7);
    check("lb_req_drop", 32'(dmem_req), 32'd0);
    check("lb_fault", 32'(fault_out), 32'd0);

    // Extension and mem_to_reg variants.
    do_load("lh",   3'b001, 32'h102, 32'h8001_1234, 1'b1, 32'hFFFF_8001);
    do_load("lhu",  3'b101, 32'h102, 32'h8001_1234, 1'b1, 32'h0000_8001);
    do_load("lbu",  3'b100, 32'h101, 32'h0000_F200, 1'b1, 32'h0000_00F2);
    do_load("lw",   3'b010, 32'h104, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
    do_load("nm2r", 3'b000, 32'h100, 32'hFFFF_FFFF, 1'b0, 32'h0000_0100);

    // SH at 0x2002, ack in the first WAIT cycle (minimum latency).
    drive(1'b1, 32'h2002, 32'hDEAD_BEEF, 5'd4, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle_in();
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh_we", 32'(dmem_we), 32'd1);
    check("sh_addr", dmem_addr, 32'h2000);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("sh_valid", 32'(valid_out), 32'd1);
    check("sh_rw", 32'(reg_write_out), 32'd0);
    check("sh_req_drop", 32'(dmem_req), 32'd0);

    // SB at 0x3.
    drive(1'b1, 32'h3, 32'h1234_5678, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle_in();
    check("sb_be", 32'(dmem_be), 32'h8);
    check("sb_wdata", dmem_wdata, 32'h7878_7878);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("sb_valid", 32'(valid_out), 32'd1);

    // Misaligned LW and illegal funct3 load.
    drive(1'b1, 32'h5, 32'h0, 5'd3, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 check("mis_stall", 32'(stall_out), 32'd0);
    tick();
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_valid", 32'(valid_out), 32'd1);
    check("mis_rw", 32'(reg_write_out), 32'd0);
    check("mis_fault", 32'(fault_out), 32'd1);
    check("mis_cause", 32'(fault_cause_out), 32'd1);
    drive(1'b1, 32'h0, 32'h0, 5'd3, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("ill_req", 32'(dmem_req), 32'd0);
    check("ill_fault", 32'(fault_out), 32'd1);
    check("ill_cause", 32'(fault_cause_out), 32'd3);
    idle_in();
    tick();
    check("fault_pulse", 32'(fault_out), 32'd0);

    // Timeout: req must stay high exactly TIMEOUT_CYCLES cycles.
    drive(1'b1, 32'h40, 32'h0, 5'd6, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    req_cnt = 0;
    while (dmem_req && req_cnt < 20) begin
      req_cnt++;
      tick();
    end
    check("to_req_cycles", 32'(req_cnt), 32'd4);
    check("to_fault", 32'(fault_out), 32'd1);
    check("to_cause", 32'(fault_cause_out), 32'd2);
    check("to_valid", 32'(valid_out), 32'd1);
    check("to_rw", 32'(reg_write_out), 32'd0);
    check("to_stall", 32'(stall_out), 32'd0);

    // Ack on the final timeout cycle wins.
    drive(1'b1, 32'h40, 32'h0, 5'd6, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    tick(); tick(); tick();
    check("late_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    tick();
    dmem_ack = 1'b0;
    check("late_fault", 32'(fault_out), 32'd0);
    check("late_valid", 32'(valid_out), 32'd1);
    check("late_wb", wb_data_out, 32'h1122_3344);
    check("late_rw", 32'(reg_write_out), 32'd1);

    // Reset during the second WAIT cycle, then a stray ack.
    drive(1'b1, 32'h80, 32'h0, 5'd2, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    idle_in();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_req", 32'(dmem_req), 32'd0);
    check("rw_valid", 32'(valid_out), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_ack = 1'b0;
    check("stray_valid", 32'(valid_out), 32'd0);
    check("stray_req", 32'(dmem_req), 32'd0);
    drive(1'b1, 32'hABCD, 32'h0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    check("post_valid", 32'(valid_out), 32'd1);
    check("post_wb", wb_data_out, 32'hABCD);
    check("post_rd", 32'(rd_out), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
